// File: rtl/uart_pkg.sv
// Shared types and limits for the configurable UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_pkg;

    localparam int BIT_CLK_MIN   = 4;
    localparam int BIT_CLK_MAX   = 4095;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Reset presets both stages high so the line reads idle.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a one-deep holding register.
// Define UART_RX_PARITY_EN to receive and check a parity bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BIT_CLK    = 87,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxdata,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rts,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(BIT_CLK);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'(BIT_CLK / 2);
    localparam logic [CW-1:0] LAST     = CW'(BIT_CLK - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          SIDX_LAST = 1'(STOP_BITS - 1);

    if (BIT_CLK < BIT_CLK_MIN || BIT_CLK > BIT_CLK_MAX) begin : g_bad_bit_clk
        $error("uart_rx_cfg: BIT_CLK out of range");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS out of range");
    end
    if (PARITY_ODD != int'(PAR_EVEN) && PARITY_ODD != int'(PAR_ODD)) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
    end

    logic rxd_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 sidx_q, sidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 deliver;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif

    logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sidx_d  = sidx_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF && rxd_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF) begin
                    shift_d[idx_q] = rxd_s;
                end
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        sidx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF) begin
                    perr_d = rxd_s != ((^shift_q) ^ (PARITY_ODD != 0));
                end
                if (cnt_q == LAST) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    sidx_d  = 1'b0;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF) begin
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                    end
                    // Return to IDLE mid-bit so the next start edge is not missed
                    if (sidx_q == SIDX_LAST) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == LAST) begin
                    sidx_d = sidx_q + 1'b1;
                    cnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rxdata_d     = rxdata_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rxdata_d    = shift_d;
                rx_valid_d  = 1'b1;
                frame_err_d = ferr_d;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_d;
`else
                parity_err_d = 1'b0;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sidx_q       <= 1'b0;
            shift_q      <= '0;
            ferr_q       <= 1'b0;
            rxdata_q     <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sidx_q       <= sidx_d;
            shift_q      <= shift_d;
            ferr_q       <= ferr_d;
            rxdata_q     <= rxdata_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    assign rxdata     = rxdata_q;
    assign rx_valid   = rx_valid_q;
    assign rts        = ~rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames, glitch,
// framing error, overrun and mid-frame reset.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BC = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MAX = 2 + 10 * BC + BC / 2 + 1;
`else
    localparam int LAT_MAX = 2 + 9 * BC + BC / 2 + 1;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rxdata;
    logic       rx_valid, rts, frame_err, parity_err, overrun;

    int   total = 0;
    int   bad = 0;
    int   ovr_seen = 0;
    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .BIT_CLK    (BC),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .rxd        (rxd),
        .rxdata     (rxdata),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rts        (rts),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bitx(logic v);
        rxd = v;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] d, logic stop, logic par,
                        bit push, logic fe, logic pe);
        if (push) sbq.push_back('{d, fe, pe});
        bitx(1'b0);
        for (int i = 0; i < 8; i++) bitx(d[i]);
`ifdef UART_RX_PARITY_EN
        bitx(par);
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        bitx(stop);
        bitx(1'b1);
        bitx(1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("rts_inv", rts, !rx_valid);
            if (overrun) ovr_seen++;
            if (rx_valid && rx_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h want none", rxdata);
                end else begin
                    e = sbq.pop_front();
                    check("rxdata", rxdata, e.d);
                    check("frame_err", frame_err, e.fe);
                    check("parity_err", parity_err, e.pe);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rxdata", rxdata, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_rts", rts, 1);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_state", dut.state_q, IDLE);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // basic frame with latency bound and single-cycle valid
        fork
            send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                int n;
                n = 0;
                @(posedge clk);
                while (!rx_valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("latency_ok", (n > 0 && n <= LAT_MAX), 1);
                @(posedge clk);
                #1;
                check("valid_1cyc", rx_valid, 0);
            end
        join

        // 4-cycle glitch is rejected at the start-bit midpoint
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("glitch_idle", dut.state_q, IDLE);
        check("glitch_novalid", rx_valid, 0);
        repeat (3 * BC) @(posedge clk);
        #1;

        // stop bit low
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // overrun while holding
        rx_ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_valid", rx_valid, 1);
        check("hold_rts", rts, 0);
        check("hold_data", rxdata, 8'h11);
        check("ovr_once", ovr_seen, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", rx_valid, 0);
        check("release_rts", rts, 1);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // reset in the middle of the 4th data bit
        bitx(1'b0);
        bitx(1'b1);
        bitx(1'b1);
        bitx(1'b1);
        rxd = 1'b1;
        repeat (BC / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_rts", rts, 1);
        check("mid_rst_data", rxdata, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_state", dut.state_q, IDLE);
        rst_n = 1'b1;
        repeat (2 * BC) @(posedge clk);
        #1;
        send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check("queue_empty", sbq.size(), 0);
        check("ovr_total", ovr_seen, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
